// File: rtl/pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Hazard and sequencing controller for the front of the pipeline. Each cycle it
// decides whether the PC and the IF_ID register load, hold or clear, and
// whether ID/EX takes a bubble. Inputs are the decode fields of the instruction
// sitting in IF_ID, the load indication of ID/EX, the EX branch outcome and the
// data-memory busy flag.
//
// The control outputs are Mealy: combinational from the registered state and
// the current inputs. They are consumed in the same cycle by the PC and
// pipeline registers.
//
// Ports:
//   reloj          in   1   clock, rising edge
//   reset          in   1   asynchronous, active-low reset
//   opcode         in   6   IF_ID opcode field
//   rs             in   5   IF_ID rs field
//   rt             in   5   IF_ID rt field
//   id_ex_memread  in   1   instruction in ID/EX is a load
//   id_ex_rt       in   5   load destination register in ID/EX
//   branch_taken   in   1   EX resolved a taken branch this cycle
//   mem_busy       in   1   data memory not ready
//   pc_en          out  1   PC loads next value
//   if_id_en       out  1   IF_ID captures new instruction
//   if_id_clr      out  1   IF_ID resetIF, synchronous clear (wins over en)
//   id_ex_bubble   out  1   ID/EX loads NOP
//   stall_cnt      out  16  cycles with pc_en=0 since reset, saturating
//   mem_timeout    out  1   sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipe_hazard_ctrl #(
  parameter int unsigned FLUSH_CYCLES      = 1,
  parameter int unsigned LOAD_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT       = 255,
  parameter logic [5:0]  OP_J              = 6'b000010,
  parameter logic [5:0]  OP_JAL            = 6'b000011
) (
  input  logic        reloj,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic        id_ex_memread,
  input  logic [4:0]  id_ex_rt,
  input  logic        branch_taken,
  input  logic        mem_busy,
  output logic        pc_en,
  output logic        if_id_en,
  output logic        if_id_clr,
  output logic        id_ex_bubble,
  output logic [15:0] stall_cnt,
  output logic        mem_timeout
);

  // Opcodes whose rt field is a source operand.
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Multi-cycle flush/stall only needs a dedicated state when longer than one.
  localparam bit         FLUSH_MULTI  = (FLUSH_CYCLES > 32'd1);
  localparam bit         LSTALL_MULTI = (LOAD_STALL_CYCLES > 32'd1);
  localparam logic [2:0] FLUSH_LOAD   = 3'(FLUSH_CYCLES - 32'd1);
  localparam logic [2:0] LSTALL_LOAD  = 3'(LOAD_STALL_CYCLES - 32'd1);
  localparam logic [7:0] TIMEOUT_LVL  = 8'(MEM_TIMEOUT);

  // Control bundles, ordered {pc_en, if_id_en, if_id_clr, id_ex_bubble}.
  // When clr is asserted if_id_en is a don't-care and is driven 1.
  localparam logic [3:0] CTL_RUN    = 4'b1100;
  localparam logic [3:0] CTL_FREEZE = 4'b0000;
  localparam logic [3:0] CTL_FLUSH  = 4'b1111;
  localparam logic [3:0] CTL_JUMP   = 4'b1110;
  localparam logic [3:0] CTL_HOLD   = 4'b0001;
  localparam logic [3:0] CTL_RESET  = 4'b0011;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_LSTALL = 2'd1,
    ST_FLUSH  = 2'd2,
    ST_FREEZE = 2'd3
  } state_t;

  // Saturating increment helpers for the wait and stall counters.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      sat_inc8 = 8'hFF;
    end else begin
      sat_inc8 = v + 8'd1;
    end
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    if (v == 16'hFFFF) begin
      sat_inc16 = 16'hFFFF;
    end else begin
      sat_inc16 = v + 16'd1;
    end
  endfunction

  state_t      state_r;
  state_t      state_nxt_s;
  logic [2:0]  cnt_r;
  logic [2:0]  cnt_nxt_s;
  logic [7:0]  wait_cnt_r;
  logic [7:0]  wait_nxt_s;
  logic [15:0] stall_cnt_r;
  logic        mem_timeout_r;
  logic        timeout_nxt_s;

  logic        uses_rt_s;
  logic        load_use_s;
  logic        jump_s;

  logic [3:0]  run_ctl_s;
  state_t      run_state_s;
  logic [2:0]  run_cnt_s;
  logic [7:0]  run_wait_s;

  logic [3:0]  ctl_s;
  logic [3:0]  out_ctl_s;

  // Decode of the IF_ID instruction against the load sitting in ID/EX.
  always_comb begin
    uses_rt_s = 1'b0;
    case (opcode)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SW: uses_rt_s = 1'b1;
      default:                         uses_rt_s = 1'b0;
    endcase
    // Register 0 is hardwired, so a load to it never creates a dependency.
    load_use_s = id_ex_memread & (id_ex_rt != 5'd0) &
                 ((id_ex_rt == rs) | (uses_rt_s & (id_ex_rt == rt)));
    jump_s     = (opcode == OP_J) | (opcode == OP_JAL);
  end

  // RUN evaluation; also reused on the cycle the memory releases a freeze.
  always_comb begin
    run_ctl_s   = CTL_RUN;
    run_state_s = ST_RUN;
    run_cnt_s   = 3'd0;
    run_wait_s  = 8'd0;
    if (mem_busy) begin
      run_ctl_s   = CTL_FREEZE;
      run_state_s = ST_FREEZE;
      run_wait_s  = 8'd1;
    end else if (branch_taken) begin
      // Branch beats a simultaneous load-use: the flush removes the consumer.
      run_ctl_s = CTL_FLUSH;
      if (FLUSH_MULTI) begin
        run_state_s = ST_FLUSH;
        run_cnt_s   = FLUSH_LOAD;
      end else begin
        run_state_s = ST_RUN;
      end
    end else if (jump_s) begin
      // The jump itself continues into ID/EX; only the wrong-path fetch dies.
      run_ctl_s = CTL_JUMP;
    end else if (load_use_s) begin
      run_ctl_s = CTL_HOLD;
      if (LSTALL_MULTI) begin
        run_state_s = ST_LSTALL;
        run_cnt_s   = LSTALL_LOAD;
      end else begin
        run_state_s = ST_RUN;
      end
    end else begin
      run_ctl_s = CTL_RUN;
    end
  end

  // Next-state, counter and control selection for the current state.
  always_comb begin
    ctl_s       = CTL_FREEZE;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    wait_nxt_s  = wait_cnt_r;
    case (state_r)
      ST_RUN: begin
        ctl_s       = run_ctl_s;
        state_nxt_s = run_state_s;
        cnt_nxt_s   = run_cnt_s;
        wait_nxt_s  = run_wait_s;
      end
      ST_FLUSH, ST_LSTALL: begin
        if (mem_busy) begin
          // Memory stall preempts; whatever flush/stall remained is dropped.
          ctl_s       = CTL_FREEZE;
          state_nxt_s = ST_FREEZE;
          cnt_nxt_s   = 3'd0;
          wait_nxt_s  = 8'd1;
        end else begin
          if (state_r == ST_FLUSH) begin
            ctl_s = CTL_FLUSH;
          end else begin
            ctl_s = CTL_HOLD;
          end
          wait_nxt_s = 8'd0;
          if (cnt_r <= 3'd1) begin
            state_nxt_s = ST_RUN;
            cnt_nxt_s   = 3'd0;
          end else begin
            state_nxt_s = state_r;
            cnt_nxt_s   = cnt_r - 3'd1;
          end
        end
      end
      ST_FREEZE: begin
        if (mem_busy) begin
          // Branch and hazards are ignored here; RUN re-evaluates them.
          ctl_s       = CTL_FREEZE;
          state_nxt_s = ST_FREEZE;
          cnt_nxt_s   = 3'd0;
          wait_nxt_s  = sat_inc8(wait_cnt_r);
        end else begin
          // Memory ready: act as RUN in this very cycle.
          ctl_s       = run_ctl_s;
          state_nxt_s = run_state_s;
          cnt_nxt_s   = run_cnt_s;
          wait_nxt_s  = 8'd0;
        end
      end
      default: begin
        ctl_s       = CTL_FREEZE;
        state_nxt_s = ST_RUN;
        cnt_nxt_s   = 3'd0;
        wait_nxt_s  = 8'd0;
      end
    endcase

    // Timeout is flagged on the edge where the wait count reaches the limit.
    if ((state_nxt_s == ST_FREEZE) && (wait_nxt_s >= TIMEOUT_LVL)) begin
      timeout_nxt_s = 1'b1;
    end else begin
      timeout_nxt_s = mem_timeout_r;
    end
  end

  // Reset overrides the controls asynchronously so the pipe is held cleared.
  always_comb begin
    if (!reset) begin
      out_ctl_s = CTL_RESET;
    end else begin
      out_ctl_s = ctl_s;
    end
  end

  assign pc_en        = out_ctl_s[3];
  assign if_id_en     = out_ctl_s[2];
  assign if_id_clr    = out_ctl_s[1];
  assign id_ex_bubble = out_ctl_s[0];

  // State, sequencing counters and sticky timeout flag.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      state_r       <= ST_RUN;
      cnt_r         <= 3'd0;
      wait_cnt_r    <= 8'd0;
      mem_timeout_r <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      wait_cnt_r    <= wait_nxt_s;
      mem_timeout_r <= timeout_nxt_s;
    end
  end

  // Saturating count of cycles in which the PC did not advance.
  always_ff @(posedge reloj or negedge reset) begin
    if (!reset) begin
      stall_cnt_r <= 16'd0;
    end else if (!pc_en) begin
      stall_cnt_r <= sat_inc16(stall_cnt_r);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt   = stall_cnt_r;
  assign mem_timeout = mem_timeout_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//
// Directed bench for pipe_hazard_ctrl built with FLUSH_CYCLES=3 and the other
// parameters at their defaults. Inputs change on the falling clock edge and the
// Mealy outputs are sampled 1 time unit later, well away from the rising edge.
// Control outputs are compared as {pc_en, if_id_en, if_id_clr, id_ex_bubble}.
// -----------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

  logic        reloj;
  logic        reset;
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        id_ex_memread;
  logic [4:0]  id_ex_rt;
  logic        branch_taken;
  logic        mem_busy;
  logic        pc_en;
  logic        if_id_en;
  logic        if_id_clr;
  logic        id_ex_bubble;
  logic [15:0] stall_cnt;
  logic        mem_timeout;

  logic [3:0]  outs;
  int          vec_cnt;
  int          err_cnt;

  assign outs = {pc_en, if_id_en, if_id_clr, id_ex_bubble};

  pipe_hazard_ctrl #(
    .FLUSH_CYCLES      (3),
    .LOAD_STALL_CYCLES (1),
    .MEM_TIMEOUT       (255),
    .OP_J              (6'b000010),
    .OP_JAL            (6'b000011)
  ) dut (
    .reloj         (reloj),
    .reset         (reset),
    .opcode        (opcode),
    .rs            (rs),
    .rt            (rt),
    .id_ex_memread (id_ex_memread),
    .id_ex_rt      (id_ex_rt),
    .branch_taken  (branch_taken),
    .mem_busy      (mem_busy),
    .pc_en         (pc_en),
    .if_id_en      (if_id_en),
    .if_id_clr     (if_id_clr),
    .id_ex_bubble  (id_ex_bubble),
    .stall_cnt     (stall_cnt),
    .mem_timeout   (mem_timeout)
  );

  initial reloj = 1'b0;
  always #5 reloj = ~reloj;

  // Wait for the falling edge, apply one input vector, let outputs settle.
  task automatic apply(input logic [5:0] op, input logic [4:0] rs_v,
                       input logic [4:0] rt_v, input logic mr,
                       input logic [4:0] ixrt, input logic br,
                       input logic mb);
    @(negedge reloj);
    opcode        = op;
    rs            = rs_v;
    rt            = rt_v;
    id_ex_memread = mr;
    id_ex_rt      = ixrt;
    branch_taken  = br;
    mem_busy      = mb;
    #1;
  endtask

  task automatic idle();
    apply(6'b000000, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    opcode = 6'b000000; rs = 5'd5; rt = 5'd0; id_ex_memread = 1'b0;
    id_ex_rt = 5'd0; branch_taken = 1'b0; mem_busy = 1'b0;
    repeat (2) @(negedge reloj);
    #1;
    vec_cnt++;
    if (outs !== 4'b0011) begin
      err_cnt++; $display("FAIL reset_outs: got %b want %b", outs, 4'b0011);
    end
    vec_cnt++;
    if (stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      err_cnt++; $display("FAIL reset_regs: got stall=%0d to=%b want 0/0", stall_cnt, mem_timeout);
    end
    @(negedge reloj);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (outs !== 4'b1100) begin
      err_cnt++; $display("FAIL release_first: got %b want %b", outs, 4'b1100);
    end
    for (int i = 0; i < 10; i++) begin
      idle();
      vec_cnt++;
      if (outs !== 4'b1100 || stall_cnt !== 16'd0) begin
        err_cnt++; $display("FAIL release_run[%0d]: got %b stall=%0d want 1100 stall=0", i, outs, stall_cnt);
      end
    end
  endtask

  task automatic test_load_use();
    apply(6'b000000, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b0001) begin
      err_cnt++; $display("FAIL load_use_rs: got %b want %b", outs, 4'b0001);
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100 || stall_cnt !== 16'd1) begin
      err_cnt++; $display("FAIL load_use_after: got %b stall=%0d want 1100 stall=1", outs, stall_cnt);
    end
    // Load into r0 matching rs=0 must not stall.
    apply(6'b000000, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b1100) begin
      err_cnt++; $display("FAIL load_use_r0: got %b want %b", outs, 4'b1100);
    end
    idle();
    vec_cnt++;
    if (stall_cnt !== 16'd1) begin
      err_cnt++; $display("FAIL load_use_r0_cnt: got %0d want 1", stall_cnt);
    end
  endtask

  task automatic test_uses_rt();
    // addi does not read rt.
    apply(6'b001000, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b1100) begin
      err_cnt++; $display("FAIL rt_addi: got %b want %b", outs, 4'b1100);
    end
    apply(6'b000000, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b0001) begin
      err_cnt++; $display("FAIL rt_rtype: got %b want %b", outs, 4'b0001);
    end
    idle();
    vec_cnt++;
    if (stall_cnt !== 16'd2) begin
      err_cnt++; $display("FAIL rt_rtype_cnt: got %0d want 2", stall_cnt);
    end
    apply(6'b101011, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b0001) begin
      err_cnt++; $display("FAIL rt_sw: got %b want %b", outs, 4'b0001);
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100 || stall_cnt !== 16'd3) begin
      err_cnt++; $display("FAIL rt_sw_after: got %b stall=%0d want 1100 stall=3", outs, stall_cnt);
    end
  endtask

  task automatic test_branch();
    apply(6'b000000, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    vec_cnt++;
    if (outs !== 4'b1111) begin
      err_cnt++; $display("FAIL branch_c0: got %b want %b", outs, 4'b1111);
    end
    for (int i = 1; i < 3; i++) begin
      idle();
      vec_cnt++;
      if (outs !== 4'b1111) begin
        err_cnt++; $display("FAIL branch_c%0d: got %b want %b", i, outs, 4'b1111);
      end
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100) begin
      err_cnt++; $display("FAIL branch_end: got %b want %b", outs, 4'b1100);
    end
    // Branch together with load-use: the branch wins.
    apply(6'b000000, 5'd5, 5'd0, 1'b1, 5'd5, 1'b1, 1'b0);
    vec_cnt++;
    if (outs !== 4'b1111) begin
      err_cnt++; $display("FAIL branch_vs_lu: got %b want %b", outs, 4'b1111);
    end
    idle();
    idle();
    vec_cnt++;
    if (outs !== 4'b1111) begin
      err_cnt++; $display("FAIL branch_vs_lu_c2: got %b want %b", outs, 4'b1111);
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100 || stall_cnt !== 16'd3) begin
      err_cnt++; $display("FAIL branch_vs_lu_end: got %b stall=%0d want 1100 stall=3", outs, stall_cnt);
    end
  endtask

  task automatic test_jump();
    apply(6'b000010, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b1110) begin
      err_cnt++; $display("FAIL jump_j: got %b want %b", outs, 4'b1110);
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100) begin
      err_cnt++; $display("FAIL jump_j_after: got %b want %b", outs, 4'b1100);
    end
    apply(6'b000011, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b1110) begin
      err_cnt++; $display("FAIL jump_jal: got %b want %b", outs, 4'b1110);
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100) begin
      err_cnt++; $display("FAIL jump_jal_after: got %b want %b", outs, 4'b1100);
    end
  endtask

  task automatic test_mem_timeout();
    logic exp_to;
    // Cycle i (1-based) is sampled after i-1 busy edges; the flag appears
    // once 255 busy edges have passed.
    for (int i = 1; i <= 300; i++) begin
      apply(6'b000000, 5'd5, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      exp_to = (i >= 256);
      vec_cnt++;
      if (outs !== 4'b0000 || mem_timeout !== exp_to) begin
        err_cnt++; $display("FAIL mem_busy[%0d]: got %b to=%b want 0000 to=%b", i, outs, mem_timeout, exp_to);
      end
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100 || mem_timeout !== 1'b1 || stall_cnt !== 16'd303) begin
      err_cnt++; $display("FAIL mem_release: got %b to=%b stall=%0d want 1100 to=1 stall=303", outs, mem_timeout, stall_cnt);
    end
    idle();
    vec_cnt++;
    if (mem_timeout !== 1'b1 || stall_cnt !== 16'd303) begin
      err_cnt++; $display("FAIL mem_sticky: got to=%b stall=%0d want to=1 stall=303", mem_timeout, stall_cnt);
    end
  endtask

  task automatic test_freeze_exit();
    // Branch during freeze is ignored.
    apply(6'b000000, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 1'b1);
    vec_cnt++;
    if (outs !== 4'b0000) begin
      err_cnt++; $display("FAIL freeze_branch: got %b want %b", outs, 4'b0000);
    end
    // Memory ready with a load-use present: RUN evaluation that cycle.
    apply(6'b000000, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, 1'b0);
    vec_cnt++;
    if (outs !== 4'b0001) begin
      err_cnt++; $display("FAIL freeze_exit_lu: got %b want %b", outs, 4'b0001);
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100 || stall_cnt !== 16'd305 || mem_timeout !== 1'b1) begin
      err_cnt++; $display("FAIL freeze_exit_after: got %b stall=%0d to=%b want 1100 stall=305 to=1", outs, stall_cnt, mem_timeout);
    end
  endtask

  task automatic test_reset_mid_flush();
    apply(6'b000000, 5'd5, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    idle();
    vec_cnt++;
    if (outs !== 4'b1111) begin
      err_cnt++; $display("FAIL midflush_pre: got %b want %b", outs, 4'b1111);
    end
    #2;
    reset = 1'b0;
    #1;
    vec_cnt++;
    if (outs !== 4'b0011 || stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      err_cnt++; $display("FAIL midflush_reset: got %b stall=%0d to=%b want 0011 stall=0 to=0", outs, stall_cnt, mem_timeout);
    end
    @(negedge reloj);
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (outs !== 4'b1100 || stall_cnt !== 16'd0) begin
      err_cnt++; $display("FAIL midflush_release: got %b stall=%0d want 1100 stall=0", outs, stall_cnt);
    end
    idle();
    vec_cnt++;
    if (outs !== 4'b1100 || stall_cnt !== 16'd0 || mem_timeout !== 1'b0) begin
      err_cnt++; $display("FAIL midflush_run: got %b stall=%0d to=%b want 1100 stall=0 to=0", outs, stall_cnt, mem_timeout);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    test_reset();
    test_load_use();
    test_uses_rt();
    test_branch();
    test_jump();
    test_mem_timeout();
    test_freeze_exit();
    test_reset_mid_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the front of the pipeline: PC register, IF_ID stage register, and the bubble input of ID/EX.
- Decides each cycle whether PC and IF_ID load, hold or clear, from the IF_ID decode fields, the ID/EX load indication, the EX branch result and data-memory busy.
- Drives resetIF of the IF_ID register directly.
- Keeps a saturating stall-cycle counter and a sticky memory-timeout flag.

Parameters:
- FLUSH_CYCLES, 1, cycles of IF_ID clear after a taken branch (1..7).
- LOAD_STALL_CYCLES, 1, cycles PC/IF_ID hold on a load-use hazard (1..7).
- MEM_TIMEOUT, 255, consecutive mem_busy cycles that set mem_timeout (1..255).
- OP_J, 6'b000010, jump opcode. OP_JAL, 6'b000011, jump-and-link opcode.

Ports:
- reloj  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IF_ID opcode field
- rs  in  5  IF_ID rs field
- rt  in  5  IF_ID rt field
- id_ex_memread  in  1  instruction in ID/EX is a load
- id_ex_rt  in  5  load destination register in ID/EX
- branch_taken  in  1  EX resolved a taken branch this cycle
- mem_busy  in  1  data memory not ready
- pc_en  out  1  PC loads next value
- if_id_en  out  1  IF_ID captures new instruction
- if_id_clr  out  1  to IF_ID resetIF; synchronous clear
- id_ex_bubble  out  1  ID/EX loads NOP
- stall_cnt  out  16  cycles with pc_en=0 since reset, saturating at 16'hFFFF
- mem_timeout  out  1  sticky, set on memory timeout

Behaviour:
- Registered state is one of RUN, LSTALL, FLUSH, FREEZE, plus a 3-bit cnt, 8-bit wait_cnt, stall_cnt and mem_timeout.
- Outputs are combinational (Mealy) from state and inputs.
- While reset=0:
  - state=RUN, cnt=0, wait_cnt=0, stall_cnt=0, mem_timeout=0.
  - Outputs forced pc_en=0, if_id_en=0, if_id_clr=1, id_ex_bubble=1.
  - Assertion mid-operation aborts any state immediately.
- uses_rt = opcode in {000000, 000100, 000101, 101011}.
- load_use = id_ex_memread & (id_ex_rt!=0) & ((id_ex_rt==rs) | (uses_rt & id_ex_rt==rt)).
- jump = opcode==OP_J | opcode==OP_JAL.
- RUN, priority highest first; the default output is pc_en=1, if_id_en=1, clr=0, bubble=0:
  1. mem_busy: pc_en=0, if_id_en=0, clr=0, bubble=0. Next state FREEZE, wait_cnt=1.
  2. branch_taken: pc_en=1, clr=1, bubble=1. If FLUSH_CYCLES>1, next state FLUSH with cnt=FLUSH_CYCLES-1, else stay RUN.
  3. jump: pc_en=1, clr=1, bubble=0. Stay RUN; the jump instruction itself proceeds to ID/EX.
  4. load_use: pc_en=0, if_id_en=0, bubble=1. If LOAD_STALL_CYCLES>1, next state LSTALL with cnt=LOAD_STALL_CYCLES-1.
- FLUSH:
  - Outputs pc_en=1, clr=1, bubble=1; cnt decrements; return to RUN when cnt reaches 1.
  - mem_busy overrides: output freeze values and go to FREEZE; the remaining flush is dropped.
- LSTALL:
  - Outputs pc_en=0, if_id_en=0, bubble=1; cnt decrements; return to RUN when cnt reaches 1.
  - mem_busy overrides as in FLUSH.
- FREEZE:
  - Outputs pc_en=0, if_id_en=0, clr=0, bubble=0.
  - branch_taken and hazards are ignored; they are re-evaluated in RUN.
  - wait_cnt increments each cycle mem_busy=1, saturating at 255. When wait_cnt reaches MEM_TIMEOUT, mem_timeout is set; only reset clears it.
  - When mem_busy=0: outputs take the RUN evaluation that same cycle, next state RUN, wait_cnt=0.
- stall_cnt increments on every edge with reset=1 and pc_en=0; it holds at FFFF.
- if_id_clr wins over if_id_en in the IF_ID register. When clr=1, if_id_en is don't-care (driven 1).
- Simultaneous branch_taken and load_use: the branch wins; the clear/bubble removes the hazard source.

Test Plan:
- Reset release, opcode=0, no hazards -> first cycle pc_en=1, if_id_en=1, clr=0, bubble=0; stall_cnt stays 0 for 10 cycles.
- id_ex_memread=1, id_ex_rt=5, rs=5 (defaults) -> one cycle pc_en=0, if_id_en=0, bubble=1; stall_cnt=1. Same with id_ex_rt=0 -> no stall.
- rt=7, id_ex_rt=7, opcode=001000 (addi, no rt use) -> no stall; opcode=000000 -> stall.
- branch_taken=1 with FLUSH_CYCLES=3 -> clr=1, bubble=1 for 3 consecutive cycles, then RUN. opcode=000010 -> clr=1 for exactly 1 cycle, bubble=0.
- mem_busy high 300 cycles, MEM_TIMEOUT=255 -> pc_en=0 throughout; mem_timeout rises at cycle 255 and stays after mem_busy drops; stall_cnt=300.
- reset pulled low mid-FLUSH -> outputs immediately pc_en=0, clr=1; after release, state RUN, counters 0.
